stream_buffer_out_mc: RTL and testbench
=======================================

# stream_buffer_out_mc

Multi-channel, parametrised playback buffer: NUM_CH independent sample memories, each DEPTH × DATA_W. All channels are read in lockstep and presented as one concatenated AXI4-Stream master. The block generalises the single-channel stream output buffer with:
- per-channel enables;
- an arbitrary start/end window with wrap-around;
- finite or infinite looping;
- optional external-trigger arming.

It sits between the host-side buffer-fill path (AXI slave adapter, external to this block) and the downstream DAC/stream consumer.

## Interface
Parameters:
- NUM_CH, 4, number of channels (1..8)
- DATA_W, 32, sample width per channel
- DEPTH, 1024, words per channel memory (power of two); AW = clog2(DEPTH)

Ports:
- ACLK  in  1  sole clock
- ARESET  in  1  synchronous, active-high reset
- wr_en  in  1  host write strobe
- wr_ch  in  clog2(NUM_CH)  channel select for write
- wr_addr  in  AW  write address
- wr_data  in  DATA_W  write data
- cfg_start_addr  in  AW  first word of playback window
- cfg_end_addr  in  AW  last word of playback window (inclusive)
- cfg_loops  in  16  number of passes; 0 = infinite
- cfg_ch_en  in  NUM_CH  channel enable mask; disabled lanes output zero
- cfg_trig_mode  in  1  1 = arm and wait for ext_trig
- ctrl_start  in  1  start pulse
- ctrl_stop  in  1  stop pulse
- ext_trig  in  1  trigger pulse
- m_axis_tdata  out  NUM_CH*DATA_W  channel c occupies bits [c*DATA_W +: DATA_W]
- m_axis_tvalid  out  1  AXI4-Stream valid
- m_axis_tready  in  1  AXI4-Stream ready
- m_axis_tlast  out  1  high on the last word of each pass
- status_busy  out  1  state is not IDLE
- status_armed  out  1  state is ARMED
- status_pass_cnt  out  16  completed passes since start
- status_done  out  1  one-cycle pulse when finite playback completes

## Operation
- **Memories.** One simple-dual-port RAM per channel.
  - Write port: wr_en/wr_ch/wr_addr.
  - Read port: shared read pointer, 1-cycle registered read latency, read-first on same-address collision.
  - Writes are accepted in every state, including RUN.
- **Configuration capture.** cfg_* is latched on an accepted ctrl_start. Later changes to cfg_* have no effect until the next start.
- **Window.** Pass length L = ((end - start) mod DEPTH) + 1, computed in AW bits.
  - start > end wraps through DEPTH-1 to 0.
  - start == end gives L = 1.
- **State machine (IDLE, ARMED, RUN, DRAIN):**
  - IDLE → ctrl_start: ARMED if cfg_trig_mode, else RUN.
  - ARMED → ext_trig: RUN. ARMED → ctrl_stop: IDLE.
  - RUN issues a read whenever the 2-entry output skid has space. The read pointer increments mod DEPTH. After reading end_addr, the pointer reloads start_addr and the pass counter increments.
  - RUN → DRAIN once the final read is issued (finite loops), or on ctrl_stop.
  - DRAIN issues no reads. It empties the skid and in-flight read, then goes to IDLE.
  - On the DRAIN → IDLE transition of a finite run, status_done pulses. A stop-initiated drain does not pulse status_done.
- **Stop.** ctrl_stop discards skid entries not yet presented. The beat currently on the bus (tvalid=1) is held until accepted, per AXI4-Stream rules; then tvalid drops.
- **tlast.** Accompanies the beat read from end_addr.
- **Lane masking.** Disabled lanes are zeroed at the output register, using the latched mask.
- **status_pass_cnt.** Increments when a tlast beat is accepted. Clears on accepted start. Saturates at 0xFFFF.
- **Simultaneous events:**
  - ctrl_start and ctrl_stop in the same cycle: stop wins (start ignored).
  - ctrl_start while busy: ignored.
  - ext_trig outside ARMED: ignored.
  - ext_trig and ctrl_stop in ARMED: stop wins.

## Timing
- **Reset.** ARESET high at a clock edge forces IDLE and clears the pointer, counters and skid. All outputs go to 0: tdata, tvalid, tlast, busy, armed, pass_cnt, done. RAM contents are not cleared.
- **Reset mid-run.** Takes effect at the next edge; tvalid drops with no handshake.
- **Start latency (cfg_trig_mode = 0).** Edge sampling ctrl_start is cycle 0: RUN at cycle 1, first read at cycle 1, tvalid high at cycle 2.
- **Trigger latency.** Same latency, measured from the edge sampling ext_trig.
- **Throughput.** With tready held high: one beat per cycle, no bubbles, including across the wrap and pass boundaries.
- **Backpressure.** Any tready pattern loses and duplicates no word. Skid depth 2 covers the 1-cycle read latency.
- **status_done.** Asserted the cycle after the final beat handshake, for one cycle.

## Test plan
- **Basic one-shot.** Fill ch0..3 with word = ch*0x1000 + addr, addr 0..7. start=0, end=7, loops=1, mask=0xF, tready=1.
  - Expect 8 beats; beat k = {0x3000+k, 0x2000+k, 0x1000+k, k}.
  - tlast on k=7; first tvalid 2 cycles after start; status_done 1 cycle after the last beat; pass_cnt=1.
- **Wrap and loop.** DEPTH=1024, start=1022, end=1, loops=3.
  - Expect address sequence 1022,1023,0,1 repeated 3 times with tlast on each address-1 beat.
  - 12 beats total; pass_cnt=3.
- **Backpressure and mask.** tready random at 30%, mask=0x5, loops=2 over 16 words.
  - Expect all 32 beats in order with lanes 1 and 3 equal to 0; no gaps or duplicates versus the reference model.
- **Infinite loop, stop.** loops=0, window 4 words, assert ctrl_stop mid-pass while tvalid=1 and tready=0.
  - Expect the held beat to complete when tready rises, then tvalid=0 and IDLE.
  - status_done stays 0.
- **Triggered arm.** cfg_trig_mode=1, start pulse.
  - Expect armed=1, tvalid=0 for 100 cycles.
  - ext_trig pulse → tvalid 2 cycles later.
  - A second start while busy is ignored.
  - start and stop in the same cycle from IDLE → remains IDLE.
- **Reset mid-run and write collision.**
  - Write address 5 in the same cycle it is read: old data is streamed.
  - Assert ARESET during RUN: all outputs 0 the next cycle.
  - A subsequent start replays the updated RAM contents.

Source files
------------

// File: rtl/stream_buffer_out_mc.sv
// stream_buffer_out_mc
// Multi-channel playback buffer. NUM_CH sample memories are read in lockstep
// over a start/end window (with wrap-around) and streamed as one concatenated
// AXI4-Stream master. Supports finite or infinite looping, per-lane enables
// and optional arming on an external trigger.
module stream_buffer_out_mc #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 1024,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                     ACLK,
    input  logic                     ARESET,
    input  logic                     wr_en,
    input  logic [CW-1:0]            wr_ch,
    input  logic [AW-1:0]            wr_addr,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic [AW-1:0]            cfg_start_addr,
    input  logic [AW-1:0]            cfg_end_addr,
    input  logic [15:0]              cfg_loops,
    input  logic [NUM_CH-1:0]        cfg_ch_en,
    input  logic                     cfg_trig_mode,
    input  logic                     ctrl_start,
    input  logic                     ctrl_stop,
    input  logic                     ext_trig,
    output logic [NUM_CH*DATA_W-1:0] m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic                     status_busy,
    output logic                     status_armed,
    output logic [15:0]              status_pass_cnt,
    output logic                     status_done
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2,
        ST_DRAIN = 2'd3
    } state_t;

    localparam int TW = NUM_CH * DATA_W;

    state_t state_r;
    state_t state_s;

    // Configuration latched on an accepted start
    logic [AW-1:0]     start_r;
    logic [AW-1:0]     end_r;
    logic [15:0]       loops_r;
    logic [NUM_CH-1:0] mask_r;
    logic              aborted_r;

    // Read side
    logic [AW-1:0]     rd_ptr_r;
    logic [15:0]       rd_pass_r;
    logic              rd_vld_r;
    logic              rd_last_r;
    logic [DATA_W-1:0] mem_r     [NUM_CH][DEPTH];
    logic [DATA_W-1:0] rd_data_r [NUM_CH];
    logic [TW-1:0]     rd_masked_s;

    // Two-entry output skid; entry 0 is the bus register
    logic          e0_vld_r, e1_vld_r, e0_vld_s, e1_vld_s;
    logic          e0_last_r, e1_last_r, e0_last_s, e1_last_s;
    logic [TW-1:0] e0_data_r, e1_data_r, e0_data_s, e1_data_s;

    // Status registers
    logic [15:0] pass_cnt_r;
    logic        done_r;
    logic        busy_r;
    logic        armed_r;

    // Control decode
    logic       start_acc_s;
    logic       pop_s;
    logic       flush_s;
    logic [1:0] occ_s;
    logic       space_s;
    logic       last_rd_s;
    logic       final_rd_s;
    logic       rd_issue_s;
    logic       drain_empty_s;
    logic       done_s;

    assign start_acc_s   = (state_r == ST_IDLE) && ctrl_start && !ctrl_stop;
    assign pop_s         = e0_vld_r && m_axis_tready;
    assign flush_s       = ctrl_stop && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    // Skid entries plus the in-flight read never exceed two, so 2 bits suffice
    assign occ_s         = {1'b0, e0_vld_r} + {1'b0, e1_vld_r} + {1'b0, rd_vld_r};
    assign space_s       = (occ_s - {1'b0, pop_s}) < 2'd2;
    assign last_rd_s     = (rd_ptr_r == end_r);
    assign final_rd_s    = last_rd_s && (loops_r != 16'd0) && (rd_pass_r == (loops_r - 16'd1));
    assign rd_issue_s    = (state_r == ST_RUN) && !ctrl_stop && space_s;
    assign drain_empty_s = !rd_vld_r && !e1_vld_r && (!e0_vld_r || pop_s);
    assign done_s        = (state_r == ST_DRAIN) && drain_empty_s && !aborted_r && !ctrl_stop;

    // Playback state register
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic; stop always takes priority over start and trigger
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_acc_s) begin
                    state_s = cfg_trig_mode ? ST_ARMED : ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (ctrl_stop) begin
                    state_s = ST_IDLE;
                end else if (ext_trig) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_ARMED;
                end
            end
            ST_RUN: begin
                if (ctrl_stop) begin
                    state_s = ST_DRAIN;
                end else if (rd_issue_s && final_rd_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (drain_empty_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    // Per-channel sample RAMs: host write port and shared registered read-first read port
    always_ff @(posedge ACLK) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (wr_en && (wr_ch == CW'(c))) begin
                mem_r[c][wr_addr] <= wr_data;
            end
            if (rd_issue_s) begin
                rd_data_r[c] <= mem_r[c][rd_ptr_r];
            end
        end
    end

    // Zero disabled lanes before the word enters the skid
    always_comb begin
        rd_masked_s = {TW{1'b0}};
        for (int c = 0; c < NUM_CH; c++) begin
            if (mask_r[c]) begin
                rd_masked_s[c*DATA_W +: DATA_W] = rd_data_r[c];
            end else begin
                rd_masked_s[c*DATA_W +: DATA_W] = {DATA_W{1'b0}};
            end
        end
    end

    // Skid next-state: stop drops everything not yet on the bus, else pop/push
    always_comb begin
        e0_vld_s  = e0_vld_r;
        e0_data_s = e0_data_r;
        e0_last_s = e0_last_r;
        e1_vld_s  = e1_vld_r;
        e1_data_s = e1_data_r;
        e1_last_s = e1_last_r;
        if (flush_s) begin
            e0_vld_s = e0_vld_r && !m_axis_tready;
            e1_vld_s = 1'b0;
        end else begin
            case ({pop_s, rd_vld_r})
                2'b10: begin
                    e0_vld_s  = e1_vld_r;
                    e0_data_s = e1_data_r;
                    e0_last_s = e1_last_r;
                    e1_vld_s  = 1'b0;
                end
                2'b01: begin
                    if (e0_vld_r) begin
                        e1_vld_s  = 1'b1;
                        e1_data_s = rd_masked_s;
                        e1_last_s = rd_last_r;
                    end else begin
                        e0_vld_s  = 1'b1;
                        e0_data_s = rd_masked_s;
                        e0_last_s = rd_last_r;
                    end
                end
                2'b11: begin
                    if (e1_vld_r) begin
                        e0_vld_s  = 1'b1;
                        e0_data_s = e1_data_r;
                        e0_last_s = e1_last_r;
                        e1_vld_s  = 1'b1;
                        e1_data_s = rd_masked_s;
                        e1_last_s = rd_last_r;
                    end else begin
                        e0_vld_s  = 1'b1;
                        e0_data_s = rd_masked_s;
                        e0_last_s = rd_last_r;
                        e1_vld_s  = 1'b0;
                    end
                end
                default: begin
                    e0_vld_s = e0_vld_r;
                end
            endcase
        end
    end

    // Skid registers (entry 0 doubles as the AXI4-Stream output register)
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            e0_vld_r  <= 1'b0;
            e0_data_r <= {TW{1'b0}};
            e0_last_r <= 1'b0;
            e1_vld_r  <= 1'b0;
            e1_data_r <= {TW{1'b0}};
            e1_last_r <= 1'b0;
        end else begin
            e0_vld_r  <= e0_vld_s;
            e0_data_r <= e0_data_s;
            e0_last_r <= e0_last_s;
            e1_vld_r  <= e1_vld_s;
            e1_data_r <= e1_data_s;
            e1_last_r <= e1_last_s;
        end
    end

    // Config capture, read pointer/pass tracking and status counters
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            start_r    <= {AW{1'b0}};
            end_r      <= {AW{1'b0}};
            loops_r    <= 16'd0;
            mask_r     <= {NUM_CH{1'b0}};
            aborted_r  <= 1'b0;
            rd_ptr_r   <= {AW{1'b0}};
            rd_pass_r  <= 16'd0;
            rd_vld_r   <= 1'b0;
            rd_last_r  <= 1'b0;
            pass_cnt_r <= 16'd0;
            done_r     <= 1'b0;
            busy_r     <= 1'b0;
            armed_r    <= 1'b0;
        end else begin
            if (start_acc_s) begin
                start_r   <= cfg_start_addr;
                end_r     <= cfg_end_addr;
                loops_r   <= cfg_loops;
                mask_r    <= cfg_ch_en;
                aborted_r <= 1'b0;
                rd_ptr_r  <= cfg_start_addr;
                rd_pass_r <= 16'd0;
            end else if (rd_issue_s) begin
                if (last_rd_s) begin
                    rd_ptr_r  <= start_r;
                    rd_pass_r <= rd_pass_r + 16'd1;
                end else begin
                    rd_ptr_r  <= rd_ptr_r + {{(AW-1){1'b0}}, 1'b1};
                end
            end
            if (flush_s) begin
                aborted_r <= 1'b1;
            end
            rd_vld_r <= rd_issue_s;
            if (rd_issue_s) begin
                rd_last_r <= last_rd_s;
            end
            if (start_acc_s) begin
                pass_cnt_r <= 16'd0;
            end else if (pop_s && e0_last_r && (pass_cnt_r != 16'hFFFF)) begin
                pass_cnt_r <= pass_cnt_r + 16'd1;
            end
            done_r  <= done_s;
            busy_r  <= (state_s != ST_IDLE);
            armed_r <= (state_s == ST_ARMED);
        end
    end

    assign m_axis_tdata    = e0_data_r;
    assign m_axis_tvalid   = e0_vld_r;
    assign m_axis_tlast    = e0_last_r;
    assign status_busy     = busy_r;
    assign status_armed    = armed_r;
    assign status_pass_cnt = pass_cnt_r;
    assign status_done     = done_r;

endmodule

// File: tb/tb_stream_buffer_out_mc.sv
// Testbench for stream_buffer_out_mc: randomized stream scenarios compared
// against a window/loop reference model of the playback sequence.
`timescale 1ns/1ps
module tb_stream_buffer_out_mc;
    localparam int NUM_CH = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 1024;
    localparam int AW     = 10;
    localparam int TW     = NUM_CH * DATA_W;

    logic              ACLK = 1'b0;
    logic              ARESET;
    logic              wr_en;
    logic [1:0]        wr_ch;
    logic [AW-1:0]     wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [AW-1:0]     cfg_start_addr;
    logic [AW-1:0]     cfg_end_addr;
    logic [15:0]       cfg_loops;
    logic [NUM_CH-1:0] cfg_ch_en;
    logic              cfg_trig_mode;
    logic              ctrl_start;
    logic              ctrl_stop;
    logic              ext_trig;
    logic [TW-1:0]     m_axis_tdata;
    logic              m_axis_tvalid;
    logic              m_axis_tready;
    logic              m_axis_tlast;
    logic              status_busy;
    logic              status_armed;
    logic [15:0]       status_pass_cnt;
    logic              status_done;

    int tests_run = 0;
    int tests_failed = 0;

    logic [DATA_W-1:0] model_mem [NUM_CH][DEPTH];
    logic [TW-1:0]     exp_data[$];
    logic              exp_last[$];
    logic [TW-1:0]     got_data[$];
    logic              got_last[$];
    int                hs_at[$];
    int                done_at[$];
    int                first_valid;

    stream_buffer_out_mc #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .wr_en(wr_en), .wr_ch(wr_ch), .wr_addr(wr_addr), .wr_data(wr_data),
        .cfg_start_addr(cfg_start_addr), .cfg_end_addr(cfg_end_addr),
        .cfg_loops(cfg_loops), .cfg_ch_en(cfg_ch_en), .cfg_trig_mode(cfg_trig_mode),
        .ctrl_start(ctrl_start), .ctrl_stop(ctrl_stop), .ext_trig(ext_trig),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tlast(m_axis_tlast),
        .status_busy(status_busy), .status_armed(status_armed),
        .status_pass_cnt(status_pass_cnt), .status_done(status_done)
    );

    always #5 ACLK = ~ACLK;

    // Reference model: the beat sequence implied by window, loop count and mask
    function automatic void build_expected(int s, int e, int loops, logic [NUM_CH-1:0] mask);
        int len;
        int a;
        logic [TW-1:0] w;
        len = (((e - s) % DEPTH) + DEPTH) % DEPTH + 1;
        exp_data.delete();
        exp_last.delete();
        for (int p = 0; p < loops; p++) begin
            for (int i = 0; i < len; i++) begin
                a = (s + i) % DEPTH;
                w = '0;
                for (int c = 0; c < NUM_CH; c++) begin
                    if (mask[c]) w[c*DATA_W +: DATA_W] = model_mem[c][a];
                end
                exp_data.push_back(w);
                exp_last.push_back(i == len - 1);
            end
        end
    endfunction

    task automatic write_word(int ch, int addr, logic [DATA_W-1:0] d);
        @(negedge ACLK);
        wr_en = 1'b1; wr_ch = 2'(ch); wr_addr = AW'(addr); wr_data = d;
        model_mem[ch][addr] = d;
        @(negedge ACLK);
        wr_en = 1'b0;
    endtask

    task automatic start_run(int s, int e, int loops, logic [NUM_CH-1:0] mask, logic trig);
        @(negedge ACLK);
        cfg_start_addr = AW'(s); cfg_end_addr = AW'(e); cfg_loops = 16'(loops);
        cfg_ch_en = mask; cfg_trig_mode = trig; ctrl_start = 1'b1;
    endtask

    // Drives tready and records handshakes/done pulses; cycle 0 is the first negedge after the start edge
    task automatic collect(int pct, int ncyc);
        got_data.delete(); got_last.delete(); hs_at.delete(); done_at.delete();
        first_valid = -1;
        for (int cyc = 0; cyc < ncyc; cyc++) begin
            @(negedge ACLK);
            ctrl_start = 1'b0; ctrl_stop = 1'b0; ext_trig = 1'b0;
            if (status_done) done_at.push_back(cyc);
            if (m_axis_tvalid && first_valid < 0) first_valid = cyc;
            m_axis_tready = ($urandom_range(99) < pct);
            if (m_axis_tvalid && m_axis_tready) begin
                got_data.push_back(m_axis_tdata);
                got_last.push_back(m_axis_tlast);
                hs_at.push_back(cyc);
            end
        end
    endtask

    task automatic test_reset();
        ARESET = 1'b1; wr_en = 1'b0; wr_ch = 2'd0; wr_addr = '0; wr_data = '0;
        cfg_start_addr = '0; cfg_end_addr = '0; cfg_loops = 16'd0; cfg_ch_en = '0;
        cfg_trig_mode = 1'b0; ctrl_start = 1'b0; ctrl_stop = 1'b0; ext_trig = 1'b0;
        m_axis_tready = 1'b0;
        repeat (3) @(negedge ACLK);
        tests_run++;
        if ({m_axis_tvalid, m_axis_tlast, status_busy, status_armed, status_done, status_pass_cnt, m_axis_tdata} !== '0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got v=%b l=%b busy=%b armed=%b done=%b pc=%0d data=%h, required all zero",
                     m_axis_tvalid, m_axis_tlast, status_busy, status_armed, status_done, status_pass_cnt, m_axis_tdata);
        end
        ARESET = 1'b0;
    endtask

    task automatic test_basic();
        logic [TW-1:0] w;
        int last_hs;
        for (int a = 0; a < 8; a++)
            for (int c = 0; c < NUM_CH; c++) write_word(c, a, DATA_W'(c * 32'h1000 + a));
        start_run(0, 7, 1, 4'hF, 1'b0);
        collect(100, 16);
        tests_run++;
        if (got_data.size() != 8) begin
            tests_failed++; $display("FAIL basic_count: got %0d beats, required 8", got_data.size());
        end
        for (int k = 0; k < 8 && k < got_data.size(); k++) begin
            w = '0;
            for (int c = 0; c < NUM_CH; c++) w[c*DATA_W +: DATA_W] = DATA_W'(c * 32'h1000 + k);
            tests_run++;
            if (got_data[k] !== w || got_last[k] !== (k == 7)) begin
                tests_failed++;
                $display("FAIL basic_beat%0d: got %h last=%b, required %h last=%b", k, got_data[k], got_last[k], w, k == 7);
            end
        end
        tests_run++;
        if (first_valid != 2) begin
            tests_failed++; $display("FAIL basic_latency: first tvalid at cycle %0d, required 2", first_valid);
        end
        last_hs = (hs_at.size() > 0) ? hs_at[$] : -100;
        tests_run++;
        if (done_at.size() != 1 || done_at[0] != last_hs + 1) begin
            tests_failed++;
            $display("FAIL basic_done: %0d pulses first at %0d, required 1 pulse at %0d", done_at.size(),
                     (done_at.size() > 0) ? done_at[0] : -1, last_hs + 1);
        end
        tests_run++;
        if (status_pass_cnt !== 16'd1 || status_busy !== 1'b0) begin
            tests_failed++; $display("FAIL basic_status: pass_cnt=%0d busy=%b, required 1 and 0", status_pass_cnt, status_busy);
        end
    endtask

    task automatic test_wrap_loop();
        int gaps;
        for (int c = 0; c < NUM_CH; c++) begin
            write_word(c, 1022, $urandom());
            write_word(c, 1023, $urandom());
        end
        build_expected(1022, 1, 3, 4'hF);
        start_run(1022, 1, 3, 4'hF, 1'b0);
        collect(100, 24);
        tests_run++;
        if (got_data.size() != 12) begin
            tests_failed++; $display("FAIL wrap_count: got %0d beats, required 12", got_data.size());
        end
        for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
            tests_run++;
            if (got_data[k] !== exp_data[k] || got_last[k] !== exp_last[k]) begin
                tests_failed++;
                $display("FAIL wrap_beat%0d: got %h last=%b, required %h last=%b", k, got_data[k], got_last[k], exp_data[k], exp_last[k]);
            end
        end
        gaps = 0;
        for (int k = 1; k < hs_at.size(); k++) if (hs_at[k] != hs_at[k-1] + 1) gaps++;
        tests_run++;
        if (gaps != 0) begin
            tests_failed++; $display("FAIL wrap_bubbles: %0d gaps, required 0", gaps);
        end
        tests_run++;
        if (status_pass_cnt !== 16'd3) begin
            tests_failed++; $display("FAIL wrap_pass_cnt: got %0d, required 3", status_pass_cnt);
        end
    endtask

    task automatic test_backpressure_mask();
        int bad_lanes;
        int last_hs;
        for (int a = 0; a < 16; a++)
            for (int c = 0; c < NUM_CH; c++) write_word(c, a, $urandom());
        build_expected(0, 15, 2, 4'h5);
        start_run(0, 15, 2, 4'h5, 1'b0);
        @(negedge ACLK);
        ctrl_start = 1'b0;
        // Changing the configuration mid-run must not affect playback
        cfg_start_addr = 10'd500; cfg_end_addr = 10'd3; cfg_loops = 16'd7; cfg_ch_en = 4'hF;
        collect(30, 400);
        tests_run++;
        if (got_data.size() != 32) begin
            tests_failed++; $display("FAIL bp_count: got %0d beats, required 32", got_data.size());
        end
        bad_lanes = 0;
        for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
            tests_run++;
            if (got_data[k] !== exp_data[k] || got_last[k] !== exp_last[k]) begin
                tests_failed++;
                $display("FAIL bp_beat%0d: got %h last=%b, required %h last=%b", k, got_data[k], got_last[k], exp_data[k], exp_last[k]);
            end
            if (got_data[k][1*DATA_W +: DATA_W] !== '0 || got_data[k][3*DATA_W +: DATA_W] !== '0) bad_lanes++;
        end
        tests_run++;
        if (bad_lanes != 0) begin
            tests_failed++; $display("FAIL bp_masked_lanes: %0d beats with nonzero lane 1/3, required 0", bad_lanes);
        end
        last_hs = (hs_at.size() > 0) ? hs_at[$] : -100;
        tests_run++;
        if (done_at.size() != 1 || done_at[0] != last_hs + 1 || status_pass_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL bp_done: %0d pulses, last hs %0d, pass_cnt=%0d, required 1 pulse after last hs and pass_cnt 2",
                     done_at.size(), last_hs, status_pass_cnt);
        end
    endtask

    task automatic test_infinite_stop();
        logic [TW-1:0] held;
        int done_seen;
        int held_bad;
        for (int a = 100; a < 104; a++)
            for (int c = 0; c < NUM_CH; c++) write_word(c, a, $urandom());
        build_expected(100, 103, 8, 4'hF);
        start_run(100, 103, 0, 4'hF, 1'b0);
        got_data.delete(); got_last.delete();
        done_seen = 0;
        for (int cyc = 0; cyc < 9; cyc++) begin
            @(negedge ACLK);
            ctrl_start = 1'b0;
            if (status_done) done_seen++;
            m_axis_tready = 1'b1;
            if (m_axis_tvalid) begin
                got_data.push_back(m_axis_tdata); got_last.push_back(m_axis_tlast);
            end
        end
        @(negedge ACLK);
        tests_run++;
        if (m_axis_tvalid !== 1'b1) begin
            tests_failed++; $display("FAIL stop_precondition: tvalid=%b, required 1", m_axis_tvalid);
        end
        held = m_axis_tdata;
        m_axis_tready = 1'b0;
        ctrl_stop = 1'b1;
        @(negedge ACLK);
        ctrl_stop = 1'b0;
        held_bad = 0;
        for (int i = 0; i < 6; i++) begin
            if (m_axis_tvalid !== 1'b1 || m_axis_tdata !== held) held_bad++;
            if (status_done) done_seen++;
            @(negedge ACLK);
        end
        tests_run++;
        if (held_bad != 0) begin
            tests_failed++; $display("FAIL stop_hold: held beat lost or changed in %0d cycles, required 0", held_bad);
        end
        m_axis_tready = 1'b1;
        got_data.push_back(m_axis_tdata); got_last.push_back(m_axis_tlast);
        @(negedge ACLK);
        tests_run++;
        if (m_axis_tvalid !== 1'b0 || status_busy !== 1'b0) begin
            tests_failed++; $display("FAIL stop_idle: tvalid=%b busy=%b, required 0 0", m_axis_tvalid, status_busy);
        end
        repeat (5) begin
            if (status_done || m_axis_tvalid) done_seen++;
            @(negedge ACLK);
        end
        tests_run++;
        if (done_seen != 0) begin
            tests_failed++; $display("FAIL stop_no_done: %0d done/valid cycles, required 0", done_seen);
        end
        tests_run++;
        if (got_data.size() != 8 || status_pass_cnt !== 16'd2) begin
            tests_failed++; $display("FAIL stop_count: %0d beats pass_cnt=%0d, required 8 and 2", got_data.size(), status_pass_cnt);
        end
        for (int k = 0; k < got_data.size(); k++) begin
            tests_run++;
            if (got_data[k] !== exp_data[k] || got_last[k] !== exp_last[k]) begin
                tests_failed++;
                $display("FAIL stop_beat%0d: got %h last=%b, required %h last=%b", k, got_data[k], got_last[k], exp_data[k], exp_last[k]);
            end
        end
    endtask

    task automatic test_trigger();
        int bad_armed;
        int bad_valid;
        build_expected(0, 7, 1, 4'hF);
        start_run(0, 7, 1, 4'hF, 1'b1);
        bad_armed = 0; bad_valid = 0;
        for (int cyc = 0; cyc < 100; cyc++) begin
            @(negedge ACLK);
            ctrl_start = 1'b0;
            m_axis_tready = 1'b1;
            if (status_armed !== 1'b1) bad_armed++;
            if (m_axis_tvalid !== 1'b0) bad_valid++;
            if (cyc == 50) begin
                // Start while busy must be ignored
                cfg_trig_mode = 1'b0; cfg_start_addr = 10'd3; cfg_ch_en = 4'h1; ctrl_start = 1'b1;
            end
        end
        tests_run++;
        if (bad_armed != 0 || bad_valid != 0) begin
            tests_failed++; $display("FAIL trig_armed_wait: %0d unarmed and %0d valid cycles, required 0", bad_armed, bad_valid);
        end
        @(negedge ACLK);
        ext_trig = 1'b1;
        collect(100, 16);
        tests_run++;
        if (first_valid != 2 || got_data.size() != 8) begin
            tests_failed++; $display("FAIL trig_latency: first tvalid %0d with %0d beats, required 2 and 8", first_valid, got_data.size());
        end
        for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
            tests_run++;
            if (got_data[k] !== exp_data[k] || got_last[k] !== exp_last[k]) begin
                tests_failed++;
                $display("FAIL trig_beat%0d: got %h, required %h", k, got_data[k], exp_data[k]);
            end
        end
        // Start together with stop from IDLE, then a stray trigger in IDLE
        @(negedge ACLK);
        cfg_trig_mode = 1'b0; ctrl_start = 1'b1; ctrl_stop = 1'b1;
        @(negedge ACLK);
        ctrl_start = 1'b0; ctrl_stop = 1'b0; ext_trig = 1'b1;
        @(negedge ACLK);
        ext_trig = 1'b0;
        bad_valid = 0;
        repeat (4) begin
            if (status_busy || status_armed || m_axis_tvalid) bad_valid++;
            @(negedge ACLK);
        end
        tests_run++;
        if (bad_valid != 0) begin
            tests_failed++; $display("FAIL trig_start_stop_idle: %0d busy cycles, required 0", bad_valid);
        end
    endtask

    task automatic test_reset_collision();
        logic [DATA_W-1:0] newv;
        newv = $urandom();
        build_expected(0, 7, 1, 4'hF);
        start_run(0, 7, 1, 4'hF, 1'b0);
        got_data.delete(); got_last.delete();
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge ACLK);
            ctrl_start = 1'b0; wr_en = 1'b0; m_axis_tready = 1'b1;
            if (cyc == 5) begin
                wr_en = 1'b1; wr_ch = 2'd2; wr_addr = 10'd5; wr_data = newv;
            end
            if (m_axis_tvalid) begin
                got_data.push_back(m_axis_tdata); got_last.push_back(m_axis_tlast);
            end
        end
        model_mem[2][5] = newv;
        tests_run++;
        if (got_data.size() != 8) begin
            tests_failed++; $display("FAIL collision_count: got %0d beats, required 8", got_data.size());
        end
        for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
            tests_run++;
            if (got_data[k] !== exp_data[k]) begin
                tests_failed++; $display("FAIL collision_beat%0d: got %h, required %h", k, got_data[k], exp_data[k]);
            end
        end
        // Reset in the middle of an infinite run
        start_run(0, 3, 0, 4'hF, 1'b0);
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge ACLK);
            ctrl_start = 1'b0; m_axis_tready = 1'b1;
        end
        tests_run++;
        if (status_pass_cnt !== 16'd2 || m_axis_tvalid !== 1'b1) begin
            tests_failed++; $display("FAIL midrun_state: pass_cnt=%0d tvalid=%b, required 2 and 1", status_pass_cnt, m_axis_tvalid);
        end
        ARESET = 1'b1;
        @(negedge ACLK);
        tests_run++;
        if ({m_axis_tvalid, m_axis_tlast, status_busy, status_armed, status_done, status_pass_cnt, m_axis_tdata} !== '0) begin
            tests_failed++;
            $display("FAIL midrun_reset: got v=%b busy=%b pc=%0d data=%h, required all zero",
                     m_axis_tvalid, status_busy, status_pass_cnt, m_axis_tdata);
        end
        ARESET = 1'b0;
        build_expected(0, 7, 1, 4'hF);
        start_run(0, 7, 1, 4'hF, 1'b0);
        collect(100, 16);
        tests_run++;
        if (got_data.size() != 8 || got_data[5][2*DATA_W +: DATA_W] !== newv) begin
            tests_failed++; $display("FAIL replay_updated: %0d beats, lane2 addr5=%h, required 8 and %h",
                                     got_data.size(), got_data[5][2*DATA_W +: DATA_W], newv);
        end
        for (int k = 0; k < exp_data.size() && k < got_data.size(); k++) begin
            tests_run++;
            if (got_data[k] !== exp_data[k]) begin
                tests_failed++; $display("FAIL replay_beat%0d: got %h, required %h", k, got_data[k], exp_data[k]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_wrap_loop();
        test_backpressure_mask();
        test_infinite_stop();
        test_trigger();
        test_reset_collision();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
